// File: rtl/dsc_s2b_rx.sv
// dsc_s2b_rx: stochastic-to-binary receiver.
// Counts ones in a serial stochastic frame and holds the result for a consumer.
module dsc_s2b_rx #(
    parameter int SNG_WIDTH  = 8,
    parameter int NUM_INPUTS = 2,
    parameter int FRAME_LEN  = 2 ** (NUM_INPUTS * SNG_WIDTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                start,
    input  logic                                sn_in,
    input  logic                                done_in,
    input  logic                                out_ready,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0]     z,
    output logic                                z_valid,
    output logic                                sat,
    output logic                                busy
);

    localparam int W  = NUM_INPUTS * SNG_WIDTH;
    localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  ones;
    logic [CW-1:0] cyc;
    logic          sat_flag;

    logic          inc_sat;
    logic [W-1:0]  ones_nxt;
    logic          sat_nxt;
    logic          frame_end;

    // Saturating next ones count and frame-end detection for the current cycle
    always_comb begin
        inc_sat  = sn_in && (ones == '1);
        ones_nxt = ones;
        if (sn_in && !inc_sat) begin
            ones_nxt = ones + 1'b1;
        end
        sat_nxt   = sat_flag | inc_sat;
        frame_end = en && (done_in || (cyc == LAST));
    end

    // Frame FSM, counters and the held result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ones     <= '0;
            cyc      <= '0;
            sat_flag <= 1'b0;
            z        <= '0;
            z_valid  <= 1'b0;
            sat      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        ones     <= '0;
                        cyc      <= '0;
                        sat_flag <= 1'b0;
                        state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (en) begin
                        ones     <= ones_nxt;
                        sat_flag <= sat_nxt;
                        if (frame_end) begin
                            z       <= ones_nxt;
                            sat     <= sat_nxt;
                            z_valid <= 1'b1;
                            state   <= S_HOLD;
                        end else begin
                            cyc <= cyc + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        z_valid <= 1'b0;
                        if (start) begin
                            ones     <= '0;
                            cyc      <= '0;
                            sat_flag <= 1'b0;
                            state    <= S_ACCUM;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_ACCUM);

endmodule

// File: tb/tb_dsc_s2b_rx.sv
// tb_dsc_s2b_rx: directed checks of dsc_s2b_rx.
// Table of per-cycle vectors plus hand sequences for long-frame cases.
module tb_dsc_s2b_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        sn_in = 1'b0;
    logic        done_in = 1'b0;
    logic        out_ready = 1'b0;

    logic [15:0] z, z_b;
    logic        z_valid, sat, busy;
    logic        z_valid_b, sat_b, busy_b;

    int n_assert = 0;
    int n_fail   = 0;

    dsc_s2b_rx #(.SNG_WIDTH(8), .NUM_INPUTS(2), .FRAME_LEN(16)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .sn_in(sn_in),
        .done_in(done_in), .out_ready(out_ready),
        .z(z), .z_valid(z_valid), .sat(sat), .busy(busy)
    );

    dsc_s2b_rx dut_big (
        .clk(clk), .rst(rst), .en(en), .start(start_b), .sn_in(sn_in),
        .done_in(done_in), .out_ready(out_ready),
        .z(z_b), .z_valid(z_valid_b), .sat(sat_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start, en, sn, done, rdy;
        logic [15:0] z;
        logic        zv, sat, busy;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic e,
                         input logic sn, input logic d, input logic rd);
        rst = r; start = s; en = e; sn_in = sn; done_in = d; out_ready = rd;
    endtask

    initial begin
        //          rst st en sn dn rdy  z      zv sat busy
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 16'd0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 0, 0, 16'd0, 0, 0, 1};
        tbl[2]  = '{0, 0, 1, 1, 0, 0, 16'd0, 0, 0, 1};
        tbl[3]  = '{0, 0, 1, 1, 0, 0, 16'd0, 0, 0, 1};
        tbl[4]  = '{0, 0, 1, 1, 0, 0, 16'd0, 0, 0, 1};
        tbl[5]  = '{0, 0, 1, 1, 1, 0, 16'd4, 1, 0, 0};
        tbl[6]  = '{0, 1, 1, 1, 1, 0, 16'd4, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 16'd4, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 16'd4, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 1, 1, 0, 16'd4, 0, 0, 1};
        tbl[10] = '{0, 0, 1, 0, 1, 0, 16'd0, 1, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 1, 16'd0, 0, 0, 1};
        tbl[12] = '{0, 1, 1, 1, 0, 0, 16'd0, 0, 0, 1};
        tbl[13] = '{0, 0, 1, 1, 0, 0, 16'd0, 0, 0, 1};
        tbl[14] = '{1, 1, 1, 1, 1, 1, 16'd0, 0, 0, 0};
        tbl[15] = '{0, 0, 1, 1, 1, 1, 16'd0, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].en, tbl[i].sn,
                  tbl[i].done, tbl[i].rdy);
            tick();
            chk($sformatf("tbl%0d_z", i), z, tbl[i].z);
            chk($sformatf("tbl%0d_zv", i), z_valid, tbl[i].zv);
            chk($sformatf("tbl%0d_sat", i), sat, tbl[i].sat);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
        end

        // Full 16-cycle frame, 5 ones, result 17 cycles after start
        drive(0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, (i == 0 || i == 3 || i == 5 || i == 9 || i == 15), 0, 0);
            tick();
            chk($sformatf("full_zv%0d", i), z_valid, (i == 15));
        end
        chk("full_z", z, 5);
        chk("full_sat", sat, 0);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("full_ack_zv", z_valid, 0);
        chk("full_ack_z", z, 5);

        // en low for 3 cycles mid-frame delays the result by 3
        drive(0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 19; i++) begin
            drive(0, 0, !(i >= 6 && i < 9), 1, 0, 0);
            tick();
            chk($sformatf("stall_zv%0d", i), z_valid, (i == 18));
        end
        chk("stall_z", z, 16);

        // Hold for 10 cycles, then accept and restart together
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 1, 1, 0);
            tick();
            chk($sformatf("hold_z%0d", i), z, 16);
            chk($sformatf("hold_zv%0d", i), z_valid, 1);
        end
        drive(0, 1, 0, 0, 0, 1);
        tick();
        chk("restart_zv", z_valid, 0);
        chk("restart_busy", busy, 1);
        chk("restart_z", z, 16);
        drive(0, 0, 1, 1, 1, 0);
        tick();
        chk("restart_end_z", z, 1);
        chk("restart_end_zv", z_valid, 1);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("restart_ack_busy", busy, 0);

        // Reset mid-frame after 7 ones discards everything
        drive(0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 1, 0, 0);
            tick();
        end
        chk("rst_pre_busy", busy, 1);
        drive(1, 0, 1, 1, 1, 0);
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_zv", z_valid, 0);
        chk("rst_z", z, 0);
        chk("rst_sat", sat, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 1, 1, 0);
            tick();
            chk($sformatf("rst_idle_zv%0d", i), z_valid, 0);
        end

        // Default parameters: all-ones 65536-cycle frame saturates
        drive(0, 0, 0, 0, 0, 0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("big_busy", busy_b, 1);
        for (int i = 0; i < 65536; i++) begin
            drive(0, 0, 1, 1, 0, 0);
            tick();
            if (i == 65534) begin
                chk("big_pre_zv", z_valid_b, 0);
                chk("big_pre_sat", sat_b, 0);
            end
        end
        chk("big_zv", z_valid_b, 1);
        chk("big_z", z_b, 65535);
        chk("big_sat", sat_b, 1);
        chk("big_busy_end", busy_b, 0);
        chk("main_idle_zv", z_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
